regwrite_arbiter: RTL
=====================

# regwrite_arbiter

Write-port arbiter and destination scoreboard for the MIPS register file. It lets two writeback sources, A (ALU) and B (load/multiply unit), share the file's single write port through valid/ready handshakes with round-robin arbitration. It tracks which registers have a write still in flight, so the issue stage can reserve destinations and stall on RAW/WAW hazards. It sits between the writeback units and the register file's `writeData`/write-address inputs.

## Interface
- `DATA_W`, default 32: width of the data path.
- `B_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes B always win a contested cycle.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `a_valid` / `b_valid`  in  1: the requester offers a write.
- `a_ready` / `b_ready`  out  1: grant; the write transfers on a cycle where valid and ready are both high.
- `a_addr` / `b_addr`  in  5: destination register.
- `a_data` / `b_data`  in  DATA_W: write data.
- `rsv_valid`  in  1: the issue stage reserves a destination.
- `rsv_addr`  in  5: the register being reserved.
- `rsv_ready`  out  1: the reservation is accepted this cycle.
- `q_addr1`, `q_addr2`  in  5: hazard query addresses, taken from the read1/read2 operands.
- `q_busy1`, `q_busy2`  out  1: the queried register has a write in flight.
- `wr_en`  out  1: registered write strobe to the register file.
- `wr_addr`  out  5: registered write address.
- `wr_data`  out  DATA_W: registered write data.
- `busy_vec`  out  32: scoreboard contents; bit 0 is always 0.

## Operation
- Arbitration is combinational from the valid inputs. `ready` depends on `valid`; `valid` must not depend on `ready`.
  - Only one requester valid: that requester is granted.
  - Both valid, `B_PRIO`=0: the side selected by `rr_ptr` is granted. `rr_ptr` flips to the other side on the next edge, and only after a contested grant.
  - Both valid, `B_PRIO`=1: B is granted; `rr_ptr` is unused.
  - At most one ready is high in any cycle. Both readies are 0 while `reset` is high.
- An accepted write is registered into `wr_en`/`wr_addr`/`wr_data` on the next edge.
  - A write to r0 is accepted, but `wr_en` stays 0.
  - If there is no transfer, `wr_en` is 0 and `wr_addr`/`wr_data` hold their last values.
- Scoreboard (`busy_vec`):
  - **Set.** On an edge where `rsv_valid` and `rsv_ready` are both high and `rsv_addr`≠0, that bit is set. Reserving r0 is always accepted and sets nothing.
  - **Clear.** On an edge where `wr_en` is 1 and `wr_addr`≠0, bit `wr_addr` is cleared.
  - **Set and clear on the same bit, same edge:** set wins.
  - **Reservation acceptance.** `rsv_ready` = !`busy_vec[rsv_addr]` OR (`wr_en` AND `wr_addr`==`rsv_addr`). This blocks WAW.
  - **Unreserved writes** are legal and leave the scoreboard unchanged.
- Queries: `q_busyN` = `busy_vec[q_addrN]`, purely combinational. Querying r0 always returns 0.

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy_vec`=0.
  - `rr_ptr`=A (A wins the first contested cycle).
  - `rsv_ready` is held at 0 during reset.
- Latency:
  - Acceptance at edge N puts `wr_en` high during cycle N+1.
  - The busy bit clears at edge N+1.
  - A query in cycle N+2 returns 0.
- Throughput: one write per cycle. Under sustained contention, grants alternate A, B, A, and so on.
- Reset asserted mid-operation:
  - A write that would transfer in that cycle is dropped.
  - Pending reservations are discarded.
  - Requesters must re-present their writes after reset.

## Configuration
- `REGARB_BYPASS_EN`
  - **Defined:** adds outputs `q_fwd1`/`q_fwd2` (1 bit) and `q_fwd_data1`/`q_fwd_data2` (DATA_W).
    - `q_fwdN` = `wr_en` AND `wr_addr`==`q_addrN` AND `q_addrN`≠0.
    - `q_fwd_dataN` = `wr_data`.
    - `q_busyN` is forced to 0 whenever `q_fwdN` is 1.
  - **Undefined:** these ports do not exist, and a query during the `wr_en` cycle returns busy=1.

## Test plan
- Reset, then `rsv_valid`=1 with `rsv_addr`=5 → `busy_vec`=0x20 next cycle; `q_addr1`=5 gives `q_busy1`=1.
- A writes r5=0xDEADBEEF alone → `a_ready`=1; next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF; `busy_vec`=0 the following cycle.
- A and B both valid for 4 cycles with `B_PRIO`=0 → grants A, B, A, B; exactly 4 `wr_en` pulses in that order.
- Reserve r7 while r7 is busy and not being written → `rsv_ready`=0. Retry in the cycle where `wr_en` is high with `wr_addr`=7 → accepted, and bit 7 remains set.
- B writes r0=0x1234 → `b_ready`=1, `wr_en` stays 0, `busy_vec` unchanged. Reserving r0 → `rsv_ready`=1, no bit set.
- With `REGARB_BYPASS_EN` defined: query r5 during the `wr_en` cycle of r5=0xCAFE → `q_fwd1`=1, `q_fwd_data1`=0xCAFE, `q_busy1`=0. Asserting reset mid-stream → `wr_en`=0 and `busy_vec`=0 next cycle.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//   Shares the register file's single write port between two writeback
//   sources (A = ALU, B = load/multiply unit) and keeps a scoreboard of
//   destination registers that have a write in flight.
//
// Parameters
//   DATA_W  width of the write data path
//   B_PRIO  0: round-robin on contested cycles, 1: B always wins a contest
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A write handshake
//   b_valid/b_ready/b_addr/b_data   requester B write handshake
//   rsv_valid/rsv_ready/rsv_addr    destination reservation from issue
//   q_addr1/q_addr2 -> q_busy1/q_busy2   hazard queries (combinational)
//   wr_en/wr_addr/wr_data       registered write to the register file
//   busy_vec                    scoreboard contents (bit 0 always 0)
//
// Optional feature macro: REGARB_BYPASS_EN
//   When defined, adds q_fwd1/q_fwd2 and q_fwd_data1/q_fwd_data2, which
//   forward the write currently on wr_* to a matching query; a forwarded
//   query reports not busy.

module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int B_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_addr,
  output logic              rsv_ready,
  input  logic [4:0]        q_addr1,
  input  logic [4:0]        q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
`ifdef REGARB_BYPASS_EN
  output logic              q_fwd1,
  output logic              q_fwd2,
  output logic [DATA_W-1:0] q_fwd_data1,
  output logic [DATA_W-1:0] q_fwd_data2,
`endif
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       busy_vec
);

  // Round-robin pointer: which side wins the next contested cycle.
  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_state_t;

  rr_state_t         rr_reg, rr_next;
  logic              xfer;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_reg;
  logic [4:0]        wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [31:0]       busy_reg, busy_next;
  logic              rsv_fire;

  // Arbitration: grants depend only on valids, pointer and reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    rr_next = rr_reg;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (B_PRIO != 0) begin
          b_ready = 1'b1;
        end else if (rr_reg == RR_A) begin
          a_ready = 1'b1;
          rr_next = RR_B;
        end else begin
          b_ready = 1'b1;
          rr_next = RR_A;
        end
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_reg <= RR_A;
    else       rr_reg <= rr_next;
  end

  // Selected write; at most one ready is high so a simple mux suffices.
  always_comb begin
    xfer     = (a_valid && a_ready) || (b_valid && b_ready);
    sel_addr = b_ready ? b_addr : a_addr;
    sel_data = b_ready ? b_data : a_data;
  end

  // Write register. Writes to r0 are accepted but never strobe the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        wr_addr_reg <= sel_addr;
        wr_data_reg <= sel_data;
      end
    end
  end

  // A reservation is refused only while its bit is busy and not being
  // retired this cycle, which keeps a second writer from overtaking (WAW).
  always_comb begin
    rsv_ready = !reset &&
                (!busy_reg[rsv_addr] || (wr_en_reg && (wr_addr_reg == rsv_addr)));
    rsv_fire  = rsv_valid && rsv_ready;
  end

  // Per-bit scoreboard update; a same-edge set overrides the clear.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign busy_next[gi] = 1'b0;
      end else begin : g_rn
        assign busy_next[gi] =
          (rsv_fire && (rsv_addr == 5'(gi)))        ? 1'b1 :
          (wr_en_reg && (wr_addr_reg == 5'(gi)))    ? 1'b0 :
                                                      busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  // Hazard queries.
`ifdef REGARB_BYPASS_EN
  always_comb begin
    q_fwd1      = wr_en_reg && (wr_addr_reg == q_addr1) && (q_addr1 != 5'd0);
    q_fwd2      = wr_en_reg && (wr_addr_reg == q_addr2) && (q_addr2 != 5'd0);
    q_fwd_data1 = wr_data_reg;
    q_fwd_data2 = wr_data_reg;
    q_busy1     = busy_reg[q_addr1] && !q_fwd1;
    q_busy2     = busy_reg[q_addr2] && !q_fwd2;
  end
`else
  always_comb begin
    q_busy1 = busy_reg[q_addr1];
    q_busy2 = busy_reg[q_addr2];
  end
`endif

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy_vec = busy_reg;

endmodule
